// File: rtl/gpio_target_tx_if.sv
// Handshake bundle between the game FSM, the GPIO target transmitter and the Arduino pins.
// master: the transmitter itself; slave: whatever sits on the other side (FSM + Arduino).
interface gpio_target_tx_if;
    logic       tx_valid;
    logic [2:0] tx_box;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;
    logic       gpio_ack;
    logic [2:0] gpio_data;
    logic       gpio_strobe;
    logic       gpio_parity;

    modport master (
        input  tx_valid, tx_box, gpio_ack,
        output tx_ready, tx_done, tx_err, gpio_data, gpio_strobe, gpio_parity
    );

    modport slave (
        output tx_valid, tx_box, gpio_ack,
        input  tx_ready, tx_done, tx_err, gpio_data, gpio_strobe, gpio_parity
    );
endinterface

// File: rtl/gpio_target_tx.sv
// Sends a 3-bit target box address to the Arduino with a 4-phase strobe/ack handshake,
// timeout and bounded retries. Define GPIO_PARITY_EN to drive an odd-parity bit on gpio_parity.
module gpio_target_tx #(
    parameter int SETUP_CYCLES   = 50,
    parameter int TIMEOUT_CYCLES = 500000,
    parameter int MAX_RETRIES    = 2
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    gpio_target_tx_if.master bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [TW-1:0] SETUP_LAST   = TW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        STROBE  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t        state_r, state_nxt;
    logic [TW-1:0] timer_r, timer_nxt;
    logic [RW-1:0] retry_r, retry_nxt;
    logic          ack_meta_r, ack_s_r;
    logic [2:0]    data_r, data_nxt;
    logic          strobe_r, strobe_nxt;
    logic          ready_r, ready_nxt;
    logic          done_r, done_nxt;
    logic          err_r, err_nxt;
    logic          accept_s, finish_ok_s, finish_err_s;

    // Two-flop synchronizer for the asynchronous Arduino acknowledge.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            ack_meta_r <= 1'b0;
            ack_s_r    <= 1'b0;
        end else begin
            ack_meta_r <= bus.gpio_ack;
            ack_s_r    <= ack_meta_r;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            timer_r  <= '0;
            retry_r  <= '0;
            data_r   <= 3'd0;
            strobe_r <= 1'b0;
            ready_r  <= 1'b1;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_nxt;
            timer_r  <= timer_nxt;
            retry_r  <= retry_nxt;
            data_r   <= data_nxt;
            strobe_r <= strobe_nxt;
            ready_r  <= ready_nxt;
            done_r   <= done_nxt;
            err_r    <= err_nxt;
        end
    end

    // Next-state logic; the timer counts cycles spent in the current phase.
    always_comb begin
        state_nxt    = state_r;
        timer_nxt    = timer_r;
        retry_nxt    = retry_r;
        accept_s     = 1'b0;
        finish_ok_s  = 1'b0;
        finish_err_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.tx_valid) begin
                    accept_s  = 1'b1;
                    retry_nxt = '0;
                    timer_nxt = '0;
                    state_nxt = SETUP;
                end else begin
                    timer_nxt = '0;
                end
            end
            SETUP: begin
                // A stale ack from the previous transfer restarts the setup window.
                if (ack_s_r) begin
                    timer_nxt = '0;
                end else if (timer_r == SETUP_LAST) begin
                    timer_nxt = '0;
                    state_nxt = STROBE;
                end else begin
                    timer_nxt = timer_r + TW'(1);
                end
            end
            STROBE: begin
                if (ack_s_r) begin
                    timer_nxt = '0;
                    state_nxt = RELEASE;
                end else if (timer_r == TIMEOUT_LAST) begin
                    timer_nxt = '0;
                    if (retry_r < RETRY_LIMIT) begin
                        retry_nxt = retry_r + RW'(1);
                        state_nxt = SETUP;
                    end else begin
                        finish_err_s = 1'b1;
                        state_nxt    = IDLE;
                    end
                end else begin
                    timer_nxt = timer_r + TW'(1);
                end
            end
            RELEASE: begin
                if (!ack_s_r) begin
                    timer_nxt   = '0;
                    finish_ok_s = 1'b1;
                    state_nxt   = IDLE;
                end else if (timer_r == TIMEOUT_LAST) begin
                    timer_nxt    = '0;
                    finish_err_s = 1'b1;
                    state_nxt    = IDLE;
                end else begin
                    timer_nxt = timer_r + TW'(1);
                end
            end
            default: begin
                timer_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Output values for the next cycle, derived from the state being entered.
    always_comb begin
        strobe_nxt = (state_nxt == STROBE);
        ready_nxt  = (state_nxt == IDLE);
        done_nxt   = finish_ok_s;
        err_nxt    = finish_err_s;
        if (accept_s) begin
            data_nxt = bus.tx_box;
        end else begin
            data_nxt = data_r;
        end
    end

    assign bus.gpio_data   = data_r;
    assign bus.gpio_strobe = strobe_r;
    assign bus.tx_ready    = ready_r;
    assign bus.tx_done     = done_r;
    assign bus.tx_err      = err_r;

`ifdef GPIO_PARITY_EN
    function automatic logic odd_parity(input logic [2:0] d);
        return ~^d;
    endfunction

    logic parity_r;

    // Parity is latched together with the address; reset value matches data=0.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            parity_r <= 1'b1;
        end else if (accept_s) begin
            parity_r <= odd_parity(bus.tx_box);
        end else begin
            parity_r <= parity_r;
        end
    end

    assign bus.gpio_parity = parity_r;
`else
    assign bus.gpio_parity = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_target_tx.sv
// Randomized bench for gpio_target_tx: a transaction-level model predicts every output each
// cycle, and directed scenarios pin strobe timing, retries, timeouts, reset and parity.
module tb_gpio_target_tx;
    localparam int SETUP_C   = 4;
    localparam int TIMEOUT_C = 20;
    localparam int RETRIES_C = 2;
    localparam int PH_QUIET  = 0;
    localparam int PH_HIGH   = 1;
    localparam int PH_LOW    = 2;
`ifdef GPIO_PARITY_EN
    localparam logic PAR_RESET = 1'b1;
`else
    localparam logic PAR_RESET = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gpio_target_tx_if bus();

    gpio_target_tx #(
        .SETUP_CYCLES  (SETUP_C),
        .TIMEOUT_CYCLES(TIMEOUT_C),
        .MAX_RETRIES   (RETRIES_C)
    ) dut (
        .CLOCK_50(clk),
        .reset   (rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_busy;
    int         m_phase, m_quiet, m_waited, m_sends;
    logic [2:0] e_data;
    logic       e_par, e_strobe, e_ready, e_done, e_err;
    bit         ack_hist[$];

    function automatic logic model_parity(input logic [2:0] b);
`ifdef GPIO_PARITY_EN
        return ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_busy = 0; e_data = 3'd0; e_par = PAR_RESET;
        e_strobe = 1'b0; e_ready = 1'b1; e_done = 1'b0; e_err = 1'b0;
        ack_hist.delete();
    endtask

    task automatic model_finish(input bit ok);
        m_busy = 0; e_done = ok; e_err = !ok;
    endtask

    task automatic model_step();
        bit a_s;
        ack_hist.push_back(bus.gpio_ack);
        while (ack_hist.size() > 3) void'(ack_hist.pop_front());
        a_s = (ack_hist.size() == 3) ? ack_hist[0] : 1'b0;   // ack seen two edges late
        e_done = 1'b0; e_err = 1'b0;
        if (!m_busy) begin
            if (bus.tx_valid) begin
                m_busy = 1; m_phase = PH_QUIET; m_quiet = 0; m_sends = 0;
                e_data = bus.tx_box; e_par = model_parity(bus.tx_box);
            end
        end else begin
            case (m_phase)
                PH_QUIET: begin
                    if (a_s) m_quiet = 0;
                    else begin
                        m_quiet++;
                        if (m_quiet == SETUP_C) begin m_phase = PH_HIGH; m_waited = 0; m_sends++; end
                    end
                end
                PH_HIGH: begin
                    m_waited++;
                    if (a_s) begin m_phase = PH_LOW; m_waited = 0; end
                    else if (m_waited == TIMEOUT_C) begin
                        if (m_sends - 1 < RETRIES_C) begin m_phase = PH_QUIET; m_quiet = 0; end
                        else model_finish(0);
                    end
                end
                default: begin
                    m_waited++;
                    if (!a_s) model_finish(1);
                    else if (m_waited == TIMEOUT_C) model_finish(0);
                end
            endcase
        end
        e_strobe = m_busy && (m_phase == PH_HIGH);
        e_ready  = !m_busy;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // Per-cycle compare of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("ready",  bus.tx_ready,    e_ready);
            check("done",   bus.tx_done,     e_done);
            check("err",    bus.tx_err,      e_err);
            check("data",   bus.gpio_data,   e_data);
            check("strobe", bus.gpio_strobe, e_strobe);
            check("parity", bus.gpio_parity, e_par);
        end
    end

    // ---------------- event monitor ----------------
    int edge_cnt = 0, done_cnt = 0, err_cnt = 0;
    int rise_q[$], fall_q[$];
    logic prev_strobe = 1'b0;

    initial begin
        forever begin
            @(posedge clk); #1;
            edge_cnt++;
            if (bus.gpio_strobe && !prev_strobe) rise_q.push_back(edge_cnt);
            if (!bus.gpio_strobe && prev_strobe) fall_q.push_back(edge_cnt);
            if (bus.tx_done) done_cnt++;
            if (bus.tx_err)  err_cnt++;
            prev_strobe = bus.gpio_strobe;
        end
    end

    function automatic int q_at(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1000;
    endfunction

    // ---------------- Arduino model ----------------
    bit ard_resp = 0, ack_force = 0;
    int ard_skip = 0, ard_dly = 3, ack_fall_edge = -1;

    initial begin
        int hi = 0, lo = 0, pulse_no = 0;
        bit prev = 0;
        bus.gpio_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!ard_resp) begin
                if (bus.gpio_ack && !ack_force) ack_fall_edge = edge_cnt;
                bus.gpio_ack = ack_force;
                hi = 0; lo = 0; pulse_no = 0; prev = 0;
            end else begin
                if (bus.gpio_strobe) begin
                    if (!prev) pulse_no++;
                    hi++; lo = 0;
                    if (hi == ard_dly && pulse_no > ard_skip) bus.gpio_ack = 1'b1;
                end else begin
                    hi = 0;
                    if (bus.gpio_ack) begin
                        lo++;
                        if (lo == ard_dly) begin bus.gpio_ack = 1'b0; lo = 0; end
                    end
                end
                prev = bus.gpio_strobe;
            end
        end
    end

    // ---------------- stimulus ----------------
    int acc_edge;

    task automatic set_ard(input bit resp, input int skip, input bit force_val);
        @(posedge clk); #2;
        ard_resp = resp; ard_skip = skip; ack_force = force_val;
        @(negedge clk);
    endtask

    task automatic send(input logic [2:0] b);
        @(negedge clk);
        bus.tx_valid = 1'b1; bus.tx_box = b;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        acc_edge = edge_cnt;
        check("data_latched", bus.gpio_data, b);
    endtask

    task automatic wait_end(input int budget, input int base);
        int n = 0;
        while (done_cnt + err_cnt == base && n < budget) begin
            @(negedge clk); n++;
        end
        check("completion", done_cnt + err_cnt - base, 1);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r0, f0, d0, e0, base;
        bus.tx_valid = 1'b0; bus.tx_box = 3'd0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready",  bus.tx_ready, 1);
        check("rst_data",   bus.gpio_data, 0);
        check("rst_strobe", bus.gpio_strobe, 0);
        check("rst_parity", bus.gpio_parity, PAR_RESET);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: normal send
        set_ard(1, 0, 0);
        r0 = rise_q.size(); d0 = done_cnt; e0 = err_cnt; base = d0 + e0;
        send(3'd5);
        wait_end(200, base);
        check("t1_strobe_delay", q_at(rise_q, r0) - acc_edge, SETUP_C);
        check("t1_done", done_cnt - d0, 1);
        check("t1_err",  err_cnt - e0, 0);
        check("t1_ready", bus.tx_ready, 1);

        // 2: stale ack held high across the request
        set_ard(0, 0, 1);
        repeat (10) @(negedge clk);
        r0 = rise_q.size(); d0 = done_cnt; base = done_cnt + err_cnt;
        send(3'd3);
        repeat (6) @(negedge clk);
        set_ard(0, 0, 0);
        set_ard(1, 0, 0);
        wait_end(200, base);
        check("t2_rise_after_quiet", q_at(rise_q, r0) - ack_fall_edge, SETUP_C + 2);
        check("t2_done", done_cnt - d0, 1);

        // 3: first strobe unanswered, second acknowledged
        set_ard(0, 0, 0);
        set_ard(1, 1, 0);
        r0 = rise_q.size(); f0 = fall_q.size(); d0 = done_cnt; e0 = err_cnt; base = d0 + e0;
        send(3'd1);
        wait_end(300, base);
        check("t3_high1", q_at(fall_q, f0) - q_at(rise_q, r0), TIMEOUT_C);
        check("t3_low",   q_at(rise_q, r0 + 1) - q_at(fall_q, f0), SETUP_C);
        check("t3_done", done_cnt - d0, 1);
        check("t3_err",  err_cnt - e0, 0);

        // 4: retry exhaustion
        set_ard(0, 0, 0);
        r0 = rise_q.size(); f0 = fall_q.size(); d0 = done_cnt; e0 = err_cnt; base = d0 + e0;
        send(3'd4);
        wait_end(400, base);
        check("t4_pulses", rise_q.size() - r0, RETRIES_C + 1);
        for (int i = 0; i < RETRIES_C + 1; i++)
            check("t4_pulse_len", q_at(fall_q, f0 + i) - q_at(rise_q, r0 + i), TIMEOUT_C);
        check("t4_err",  err_cnt - e0, 1);
        check("t4_done", done_cnt - d0, 0);
        check("t4_data", bus.gpio_data, 4);
        check("t4_ready", bus.tx_ready, 1);

        // 5: busy request ignored, then reset during strobe
        d0 = done_cnt; e0 = err_cnt;
        send(3'd2);
        for (int i = 0; i < 30 && !bus.gpio_strobe; i++) @(negedge clk);
        check("t5_strobe_high", bus.gpio_strobe, 1);
        bus.tx_valid = 1'b1; bus.tx_box = 3'd6;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_busy_ignored", bus.gpio_data, 2);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_strobe", bus.gpio_strobe, 0);
        check("t5_rst_data",   bus.gpio_data, 0);
        check("t5_rst_ready",  bus.tx_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_no_done", done_cnt - d0, 0);
        check("t5_no_err",  err_cnt - e0, 0);

        // 6: parity
        set_ard(1, 0, 0);
        base = done_cnt + err_cnt;
        send(3'd7);
`ifdef GPIO_PARITY_EN
        check("t6_par7", bus.gpio_parity, 0);
`else
        check("t6_par7_off", bus.gpio_parity, 0);
`endif
        wait_end(200, base);
        base = done_cnt + err_cnt;
        send(3'd6);
`ifdef GPIO_PARITY_EN
        check("t6_par6", bus.gpio_parity, 1);
`else
        check("t6_par6_off", bus.gpio_parity, 0);
`endif
        wait_end(200, base);

        // Random transfers with random Arduino behaviour and spurious busy requests
        for (int i = 0; i < 10; i++) begin
            set_ard(0, 0, 0);
            ard_dly = $urandom_range(1, 5);
            set_ard(1, $urandom_range(0, 3), 0);
            base = done_cnt + err_cnt;
            send(3'($urandom_range(0, 7)));
            repeat ($urandom_range(1, 5)) @(negedge clk);
            bus.tx_valid = 1'b1; bus.tx_box = 3'($urandom_range(0, 7));
            @(negedge clk);
            bus.tx_valid = 1'b0;
            wait_end(400, base);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
